// File: rtl/window_gen_layer7_pkg.sv
// ============================================================================
// Module  : window_gen_layer7_pkg
// Purpose : Shared defines, FSM state type and 3x3 tap helpers for layer 7.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef CALCULATE
`define CALCULATE 1'b1
`endif
`ifndef RSTVALID
`define RSTVALID 1'b0
`endif
`ifndef DATAVALID
`define DATAVALID 1'b1
`endif

package window_gen_layer7_pkg;

  localparam int   DATA_WIDTH   = `DATA_WIDTH;
  localparam logic CALCULATE    = `CALCULATE;
  localparam logic RSTVALID     = `RSTVALID;
  localparam logic DATAVALID    = `DATAVALID;

  localparam int   N_TAPS       = 9;
  localparam int   TAPS_PER_ROW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Newest pixel sits at line index 0, so the SE tap is 0 and NW is 2W+2.
  function automatic int tap_offset(input int tap, input int width);
    return (2 - tap / TAPS_PER_ROW) * width + (2 - tap % TAPS_PER_ROW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_gen_layer7_if.sv
// ============================================================================
// Module  : window_gen_layer7_if
// Purpose : Pixel-in / window-out bundle for the layer 7 window generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface window_gen_layer7_if #(
  parameter int FM_DEPTH = 256
);
  import window_gen_layer7_pkg::*;

  logic                         mode;
  logic                         data_e;
  logic signed [DATA_WIDTH-1:0] data_in  [FM_DEPTH];
  logic                         ready_out;
  logic signed [DATA_WIDTH-1:0] data_out [FM_DEPTH][N_TAPS];
  logic                         data_e_out;
  logic                         frame_done;

  modport master (
    output mode, data_e, data_in,
    input  ready_out, data_out, data_e_out, frame_done
  );

  modport slave (
    input  mode, data_e, data_in,
    output ready_out, data_out, data_e_out, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/window_gen_layer7_line_shift_buf.sv
// ============================================================================
// Module  : line_shift_buf
// Purpose : Enable-gated shift line; every entry is visible for tap selection.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module line_shift_buf
  import window_gen_layer7_pkg::*;
#(
  parameter int DEPTH = 31,
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en_i,
  input  wire logic [WIDTH-1:0] din_i,
  output logic      [WIDTH-1:0] line_o [DEPTH]
);

  logic [WIDTH-1:0] line_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RSTVALID) begin
      line_q <= '{default: '0};
    end else if (en_i) begin
      line_q[0] <= din_i;
      for (int i = DEPTH - 1; i > 0; i--) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign line_o = line_q;

endmodule

`default_nettype wire

// File: rtl/window_gen_layer7.sv
// ============================================================================
// Module  : window_gen_layer7
// Purpose : 3x3 zero-padded sliding-window generator (pad 1, stride 1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module window_gen_layer7
  import window_gen_layer7_pkg::*;
#(
  parameter int FM_DEPTH  = 256,
  parameter int FM_WIDTH  = 14,
  parameter int FM_HEIGHT = 14
) (
  input wire logic        clk,
  input wire logic        rst_n,
  window_gen_layer7_if.slave bus
);

  localparam int NPIX     = FM_WIDTH * FM_HEIGHT;
  localparam int LINE_LEN = 2 * FM_WIDTH + 3;
  localparam int ENTRY_W  = FM_DEPTH * DATA_WIDTH;
  localparam int CW       = $clog2(NPIX + 1);
  localparam int FW       = $clog2(FM_WIDTH + 2);
  localparam int RW       = $clog2(FM_HEIGHT + 1);
  localparam int CLW      = $clog2(FM_WIDTH + 1);

  localparam logic [CW-1:0]  C_FILL_LAST  = CW'(FM_WIDTH);
  localparam logic [CW-1:0]  C_LAST_PIX   = CW'(NPIX - 1);
  localparam logic [FW-1:0]  C_FLUSH_LAST = FW'(FM_WIDTH);
  localparam logic [RW-1:0]  C_LAST_ROW   = RW'(FM_HEIGHT - 1);
  localparam logic [CLW-1:0] C_LAST_COL   = CLW'(FM_WIDTH - 1);

  state_e                       state_q, state_d;
  logic [CW-1:0]                in_cnt_q, in_cnt_d;
  logic [FW-1:0]                flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]                out_r_q, out_r_d;
  logic [CLW-1:0]               out_c_q, out_c_d;
  logic                         fire_q, fire_d;
  logic [RW-1:0]                fire_r_q, fire_r_d;
  logic [CLW-1:0]               fire_c_q, fire_c_d;
  logic                         fire_last_q, fire_last_d;
  logic                         data_e_out_q, data_e_out_d;
  logic                         frame_done_q, frame_done_d;
  logic signed [DATA_WIDTH-1:0] data_out_q [FM_DEPTH][N_TAPS];
  logic signed [DATA_WIDTH-1:0] data_out_d [FM_DEPTH][N_TAPS];

  logic                         w_ready;
  logic                         w_accept;
  logic                         w_shift_en;
  logic                         w_fire;
  logic                         w_frame_end;
  logic [ENTRY_W-1:0]           w_din;
  logic [ENTRY_W-1:0]           w_line [LINE_LEN];
  logic [2:0]                   w_row_ok;
  logic [2:0]                   w_col_ok;
  logic signed [DATA_WIDTH-1:0] w_win [FM_DEPTH][N_TAPS];
  logic                         w_unused_line;

  assign w_ready    = (state_q != ST_FLUSH);
  assign w_accept   = (bus.mode == CALCULATE) && (bus.data_e == DATAVALID) && w_ready;
  assign w_shift_en = w_accept || ((state_q == ST_FLUSH) && (bus.mode == CALCULATE));

  // FLUSH pushes zeros; padding is masked anyway, so the value only keeps the line clean.
  always_comb begin
    w_din = '0;
    if (w_accept) begin
      for (int ch = 0; ch < FM_DEPTH; ch++) begin
        w_din[ch*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[ch];
      end
    end
  end

  line_shift_buf #(
    .DEPTH (LINE_LEN),
    .WIDTH (ENTRY_W)
  ) u_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (w_shift_en),
    .din_i  (w_din),
    .line_o (w_line)
  );

  always_comb begin
    w_unused_line = 1'b0;
    for (int i = 0; i < LINE_LEN; i++) begin
      w_unused_line = w_unused_line ^ (^w_line[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_cnt_q;
    out_r_d     = out_r_q;
    out_c_d     = out_c_q;
    w_fire      = 1'b0;
    w_frame_end = 1'b0;
    if (bus.mode != CALCULATE) begin
      state_d     = ST_IDLE;
      in_cnt_d    = '0;
      flush_cnt_d = '0;
      out_r_d     = '0;
      out_c_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (w_accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          state_d  = ST_FILL;
        end
        ST_FILL: if (w_accept) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == C_FILL_LAST) state_d = ST_RUN;
        end
        ST_RUN: if (w_accept) begin
          w_fire   = 1'b1;
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == C_LAST_PIX) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          w_fire      = 1'b1;
          flush_cnt_d = flush_cnt_q + 1'b1;
          if (flush_cnt_q == C_FLUSH_LAST) begin
            state_d     = ST_IDLE;
            w_frame_end = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (w_fire) begin
        if (out_c_q == C_LAST_COL) begin
          out_c_d = '0;
          out_r_d = out_r_q + 1'b1;
        end else begin
          out_c_d = out_c_q + 1'b1;
        end
      end
      if (w_frame_end) begin
        in_cnt_d    = '0;
        flush_cnt_d = '0;
        out_r_d     = '0;
        out_c_d     = '0;
      end
    end
  end

  // Border masks come from the centre coordinate, never from line contents.
  assign w_row_ok = {fire_r_q != C_LAST_ROW, 1'b1, fire_r_q != '0};
  assign w_col_ok = {fire_c_q != C_LAST_COL, 1'b1, fire_c_q != '0};

  for (genvar j = 0; j < N_TAPS; j++) begin : g_tap
    localparam int OFF = tap_offset(j, FM_WIDTH);
    localparam int DR  = j / TAPS_PER_ROW;
    localparam int DC  = j % TAPS_PER_ROW;
    logic w_ok;
    assign w_ok = w_row_ok[DR] & w_col_ok[DC];
    for (genvar ch = 0; ch < FM_DEPTH; ch++) begin : g_ch
      assign w_win[ch][j] = w_ok ? w_line[OFF][ch*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  always_comb begin
    fire_d      = w_fire;
    fire_r_d    = fire_r_q;
    fire_c_d    = fire_c_q;
    fire_last_d = fire_last_q;
    if (w_fire) begin
      fire_r_d    = out_r_q;
      fire_c_d    = out_c_q;
      fire_last_d = (out_r_q == C_LAST_ROW) && (out_c_q == C_LAST_COL);
    end
    data_e_out_d = fire_q && (bus.mode == CALCULATE);
    frame_done_d = data_e_out_d && fire_last_q;
    data_out_d   = data_out_q;
    if (data_e_out_d) data_out_d = w_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RSTVALID) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      flush_cnt_q  <= '0;
      out_r_q      <= '0;
      out_c_q      <= '0;
      fire_q       <= 1'b0;
      fire_r_q     <= '0;
      fire_c_q     <= '0;
      fire_last_q  <= 1'b0;
      data_e_out_q <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '{default: '0};
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      out_r_q      <= out_r_d;
      out_c_q      <= out_c_d;
      fire_q       <= fire_d;
      fire_r_q     <= fire_r_d;
      fire_c_q     <= fire_c_d;
      fire_last_q  <= fire_last_d;
      data_e_out_q <= data_e_out_d;
      frame_done_q <= frame_done_d;
      data_out_q   <= data_out_d;
    end
  end

  assign bus.ready_out  = w_ready;
  assign bus.data_e_out = data_e_out_q;
  assign bus.frame_done = frame_done_q;
  assign bus.data_out   = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_window_gen_layer7.sv
// ============================================================================
// Module  : tb_window_gen_layer7
// Purpose : Directed + random-channel bench for a 4x4x2 window generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_window_gen_layer7;
  import window_gen_layer7_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int D    = 2;
  localparam int NP   = W * H;
  localparam int DW   = DATA_WIDTH;
  localparam int WINB = D * N_TAPS * DW;
  typedef logic [WINB-1:0] win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  window_gen_layer7_if #(.FM_DEPTH(D)) bus ();

  window_gen_layer7 #(
    .FM_DEPTH  (D),
    .FM_WIDTH  (W),
    .FM_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  win_t win_q[$];
  bit   fd_q[$];
  int   orphan_fd = 0;
  int   rdy_low   = 0;
  int   frames [2][NP][D];
  int   first_taps [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  int   last_taps  [9] = '{11, 12, 0, 15, 16, 0, 0, 0, 0};

  function automatic win_t pack_out();
    win_t v = '0;
    for (int ch = 0; ch < D; ch++)
      for (int j = 0; j < N_TAPS; j++)
        v[(ch*N_TAPS+j)*DW +: DW] = bus.data_out[ch][j];
    return v;
  endfunction

  // Reference: tap (dr,dc) of centre (r,c) is pixel (r+dr-1, c+dc-1) or 0 off-map.
  function automatic win_t model_win(input int f, input int n);
    win_t v = '0;
    int r = n / W;
    int c = n % W;
    for (int ch = 0; ch < D; ch++)
      for (int j = 0; j < N_TAPS; j++) begin
        int rr = r + j / 3 - 1;
        int cc = c + j % 3 - 1;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          v[(ch*N_TAPS+j)*DW +: DW] = DW'(frames[f][rr*W+cc][ch]);
      end
    return v;
  endfunction

  always @(negedge clk) begin
    if (bus.data_e_out) begin
      win_q.push_back(pack_out());
      fd_q.push_back(bus.frame_done);
    end else if (bus.frame_done) begin
      orphan_fd++;
    end
    if (!bus.ready_out) rdy_low++;
  end

  task automatic chk(input string tag, input win_t obs, input win_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_taps(input string tag, input win_t w, input int t[9]);
    logic [9*DW-1:0] e;
    for (int j = 0; j < 9; j++) e[j*DW +: DW] = DW'(t[j]);
    chk(tag, win_t'(w[9*DW-1:0]), win_t'(e));
  endtask

  task automatic fill_frame(input int f, input int base);
    for (int p = 0; p < NP; p++) begin
      frames[f][p][0] = base + p + 1;
      frames[f][p][1] = int'($urandom_range(0, 2000)) - 1000;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_out && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", win_t'(bus.ready_out), win_t'(1));
  endtask

  // how: 0 continuous, 1 data_e toggled, 2 data_e held high with junk through FLUSH
  task automatic drive_frame(input int f, input int how, input int npix);
    wait_ready();
    for (int p = 0; p < npix; p++) begin
      for (int ch = 0; ch < D; ch++) bus.data_in[ch] = DW'(frames[f][p][ch]);
      bus.data_e = 1'b1;
      @(posedge clk); #1;
      if (how == 1) begin
        bus.data_e = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (how == 2) begin
      int n = 0;
      while (!bus.ready_out && n < 20) begin
        for (int ch = 0; ch < D; ch++) bus.data_in[ch] = DW'($urandom_range(500, 900));
        @(posedge clk); #1;
        n++;
      end
    end
    bus.data_e = 1'b0;
  endtask

  task automatic wait_windows(input string tag, input int n);
    int k = 0;
    while (win_q.size() < n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_count"}, win_t'(win_q.size()), win_t'(n));
  endtask

  task automatic check_frame(input string tag, input int f, input int start);
    logic [NP-1:0] fd_obs = '0;
    for (int n = 0; n < NP; n++) begin
      win_t obs = '0;
      if (start + n < win_q.size()) begin
        obs       = win_q[start+n];
        fd_obs[n] = fd_q[start+n];
      end
      chk($sformatf("%s_w%0d", tag, n), obs, model_win(f, n));
    end
    chk({tag, "_frame_done"}, win_t'(fd_obs), win_t'({1'b1, {(NP-1){1'b0}}}));
  endtask

  task automatic clear_q();
    win_q.delete();
    fd_q.delete();
  endtask

  initial begin
    int r0;
    int n0;
    bus.mode   = 1'b0;
    bus.data_e = 1'b0;
    for (int ch = 0; ch < D; ch++) bus.data_in[ch] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", win_t'(bus.ready_out), win_t'(1));
    chk("rst_deo", win_t'(bus.data_e_out), win_t'(0));
    chk("rst_fd", win_t'(bus.frame_done), win_t'(0));
    chk("rst_dout", pack_out(), '0);
    rst_n    = 1'b1;
    bus.mode = 1'b1;
    @(posedge clk); #1;

    // Continuous frame, ch0 = 1..16
    fill_frame(0, 0);
    clear_q();
    r0 = rdy_low;
    drive_frame(0, 0, NP);
    wait_windows("A", NP);
    check_frame("A", 0, 0);
    chk_taps("A_first_taps", win_q[0], first_taps);
    chk_taps("A_last_taps", win_q[NP-1], last_taps);
    chk("A_ready_low", win_t'(rdy_low - r0), win_t'(W + 1));
    chk("A_hold", pack_out(), model_win(0, NP - 1));

    // data_e toggled every other cycle
    fill_frame(0, 0);
    clear_q();
    r0 = rdy_low;
    drive_frame(0, 1, NP);
    wait_windows("B", NP);
    check_frame("B", 0, 0);
    chk("B_ready_low", win_t'(rdy_low - r0), win_t'(W + 1));

    // data_e held high during FLUSH, then a fresh frame
    fill_frame(0, 0);
    clear_q();
    drive_frame(0, 2, NP);
    wait_windows("C0", NP);
    check_frame("C0", 0, 0);
    fill_frame(1, 0);
    clear_q();
    drive_frame(1, 0, NP);
    wait_windows("C1", NP);
    check_frame("C1", 1, 0);
    chk_taps("C1_first_taps", win_q[0], first_taps);

    // Async reset after pixel 7
    fill_frame(0, 0);
    clear_q();
    drive_frame(0, 0, 7);
    #3 rst_n = 1'b0;
    #1;
    chk("D_rst_deo", win_t'(bus.data_e_out), win_t'(0));
    chk("D_rst_fd", win_t'(bus.frame_done), win_t'(0));
    chk("D_rst_dout", pack_out(), '0);
    chk("D_rst_ready", win_t'(bus.ready_out), win_t'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_frame(0, 0);
    clear_q();
    drive_frame(0, 0, NP);
    wait_windows("D", NP);
    check_frame("D", 0, 0);

    // mode dropped after pixel 9 for 3 cycles
    fill_frame(0, 0);
    clear_q();
    drive_frame(0, 0, 9);
    bus.mode = 1'b0;
    @(negedge clk); #1;
    n0 = win_q.size();
    chk("E_pre_count", win_t'(n0), win_t'(9 - W - 1 - 1));
    repeat (3) @(posedge clk);
    #1;
    chk("E_no_pulse", win_t'(win_q.size()), win_t'(n0));
    chk("E_idle", win_t'(dut.state_q), win_t'(ST_IDLE));
    bus.mode = 1'b1;
    fill_frame(0, 0);
    clear_q();
    drive_frame(0, 0, NP);
    wait_windows("E", NP);
    check_frame("E", 0, 0);
    chk_taps("E_first_taps", win_q[0], first_taps);

    // Two back-to-back frames, second offset by 100
    fill_frame(0, 0);
    fill_frame(1, 100);
    clear_q();
    drive_frame(0, 0, NP);
    drive_frame(1, 0, NP);
    wait_windows("F", 2 * NP);
    check_frame("F1", 0, 0);
    check_frame("F2", 1, NP);

    chk("orphan_frame_done", win_t'(orphan_fd), win_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/window_gen_layer7.md
WINDOW_GEN_LAYER7 -- requirements
Module: window_gen_layer7

Interface
REQ-001 The block SHALL have parameter FM_DEPTH, default 256, meaning channels per pixel.
REQ-002 The block SHALL have parameter FM_WIDTH, default 14, meaning feature-map columns.
REQ-003 The block SHALL have parameter FM_HEIGHT, default 14, meaning feature-map rows.
REQ-004 The block SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port mode  input  1  LOW = reload/idle, HIGH = calculate.
REQ-007 The block SHALL have port data_e  input  1  input pixel valid, active HIGH.
REQ-008 The block SHALL have port data_in  input  signed DATA_WIDTH x [FM_DEPTH]  one pixel, all channels, raster order.
REQ-009 The block SHALL have port ready_out  output  1  HIGH when data_e is accepted.
REQ-010 The block SHALL have port data_out  output  signed DATA_WIDTH x [FM_DEPTH][9]  3x3 window; tap j = 3*dr + dc, j=4 centre.
REQ-011 The block SHALL have port data_e_out  output  1  one-cycle pulse per valid window, feeds RSign data_e.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse with the last window of a frame.

Function
REQ-013 A pixel SHALL be accepted when mode HIGH, data_e HIGH and ready_out HIGH; otherwise data_in SHALL be ignored.
REQ-014 The block SHALL run a state machine with states IDLE, FILL, RUN and FLUSH.
REQ-015 IDLE->FILL on first acceptance; FILL->RUN when W+1 pixels are accepted; RUN->FLUSH on acceptance of pixel H*W-1; FLUSH->IDLE after W+1 flush cycles.
REQ-016 Storage SHALL be a pixel shift line of 2*FM_WIDTH+3 entries, advanced on each acceptance and each FLUSH cycle; FLUSH shifts in zero.
REQ-017 The window centred at (r,c) SHALL be emitted when linear pixel index r*W+c+W+1 is accepted, or on the matching FLUSH cycle when that index is at least H*W.
REQ-018 data_out and data_e_out SHALL be registered exactly 1 cycle after the triggering acceptance or FLUSH cycle.
REQ-019 Zero padding (pad 1, stride 1): taps with r+dr-1 outside 0..H-1 or c+dc-1 outside 0..W-1 SHALL be 0; column masking SHALL come from the output column counter, not from storage contents.
REQ-020 Exactly H*W windows SHALL be emitted per frame, in raster order of centre.
REQ-021 ready_out SHALL be LOW in FLUSH and HIGH in IDLE, FILL and RUN.
REQ-022 frame_done SHALL pulse in the same cycle as data_e_out for centre (H-1,W-1).
REQ-023 data_out SHALL hold its last value when data_e_out is LOW.
REQ-024 mode LOW SHALL synchronously return the FSM to IDLE, clear counters, and force data_e_out/frame_done LOW; data_out holds.
REQ-025 Gaps in data_e SHALL stall the FSM without losing state; back-to-back frames SHALL be legal after FLUSH completes.
REQ-026 Channels SHALL be independent; data values SHALL pass through unmodified (no arithmetic, no width change).

Reset
REQ-027 On rst_n LOW the FSM SHALL go to IDLE; counters, the shift line, data_out, data_e_out and frame_done SHALL clear to 0; ready_out SHALL be 1.
REQ-028 Reset mid-frame SHALL discard the partial frame; the next accepted pixel SHALL be treated as pixel (0,0).

Structure
REQ-029 The FSM state typedef and tap-index constants SHALL live in the shared layer package; DATA_WIDTH, CALCULATE, RSTVALID and DATAVALID SHALL come from defines.v.
REQ-030 The shift line SHALL be one sub-module, line_shift_buf, parameterised by depth and entry width; the FSM, counters and masking SHALL stay in the top level.

Verification
REQ-031 The bench SHALL cover this case: W=H=4, FM_DEPTH=2, pixels p=1..16 continuous -> 16 data_e_out pulses; first window taps = {0,0,0,0,1,2,0,5,6}; frame_done with window 16 = {11,12,0,15,16,0,0,0,0}.
REQ-032 The bench SHALL cover this case: same frame with data_e toggled every other cycle -> identical window sequence; ready_out LOW for exactly 5 cycles after pixel 16.
REQ-033 The bench SHALL cover this case: data_e held HIGH during FLUSH -> those inputs ignored; the next frame's first window is still {0,0,0,0,1,2,0,5,6}.
REQ-034 The bench SHALL cover this case: rst_n pulsed LOW after pixel 7 -> all outputs 0 asynchronously; a fresh 16-pixel frame then yields 16 correct windows.
REQ-035 The bench SHALL cover this case: mode dropped LOW after pixel 9 for 3 cycles -> no data_e_out pulses, FSM in IDLE; restart matches REQ-031.
REQ-036 The bench SHALL cover this case: two back-to-back frames with the second frame's values +100 -> 32 windows; no cross-frame data leaks into padding taps.
